adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
Shares one instance of the existing 32-bit ladner_fischer_adder among NREQ requesters, using valid/ready handshakes and round-robin arbitration. Accepted operations pass through a two-stage pipeline: an operand register, then the adder, then a result register. Results return on a single response channel tagged with the requester index. The block sits between ALU issue ports and the shared adder datapath.

Parameters:
NREQ, 4, number of requesters (2..16)
IDW, $clog2(NREQ) (minimum 1), width of the requester-index tag (derived localparam)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester operation valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_a  in  NREQ*32  operand A, requester i at [32*i+31:32*i]
req_b  in  NREQ*32  operand B, same packing as req_a
req_cin  in  NREQ  carry-in
req_sub  in  NREQ  1 = compute A + ~B + cin
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accept
rsp_sum  out  32  result
rsp_cout  out  1  carry-out
rsp_id  out  IDW  index of the requester that issued the result

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, stage-1 valid=0, rr pointer=0, lock state cleared. The same applies when reset asserts mid-operation; in-flight operations are discarded.
- Stall and advance:
  - stall = rsp_valid & ~rsp_ready.
  - Stage 1 can advance when it is empty or stall=0.
  - The block accepts a new request only when stage 1 can advance.
- Grant:
  - Round-robin: search from rr pointer upward with wrap-around; the first i with req_valid[i] wins.
  - req_ready[i]=1 only for the winner, only when stage 1 can advance.
  - req_ready is combinational from req_valid and internal state. req_valid must not depend on req_ready.
- On accept (req_valid[i] & req_ready[i]):
  - Stage 1 loads a, b^{32{sub}}, cin, id=i.
  - rr pointer <= (i+1) mod NREQ.
  - With no accept, the pointer holds.
- Stage 2 (when not stalled):
  - rsp_sum/rsp_cout <= adder(stage-1 a, b, cin); rsp_id <= stage-1 id; rsp_valid <= stage-1 valid.
  - If stage 1 empties and the response is consumed, rsp_valid drops to 0.
- Latency: accept in cycle N gives rsp_valid in cycle N+2 without stall. Throughput is 1 op/cycle.
- Arithmetic:
  - sum = (A + B' + cin) mod 2^32; cout = bit 32.
  - Subtraction requires the requester to drive cin=1.
  - No overflow flag.
- Boundaries:
  - All req_valid=0: no grant, pointer holds.
  - Simultaneous accept and response consumption in the same cycle is legal and keeps full throughput.
  - During stall, stage 1 and the response hold their contents bit-stable; no grant is issued.
  - A single continuously valid requester gets every slot.

Optional Feature:
ADDER_ARB_LOCK_EN
- Defined:
  - Adds input req_lock [NREQ].
  - Accepting an op with req_lock[i]=1 locks the arbiter to i. Only i can be granted until an accepted op of i has req_lock=0, which releases the lock and advances the pointer to i+1.
  - Every op accepted while locked is chained: its adder carry-in is the rsp_cout of the preceding op, taken at stage-1 compute time, instead of req_cin. The preceding op is guaranteed to be in the response register at that time.
  - If the locked requester drops req_valid, no grant is issued; there is no timeout.
  - This supports multi-word add/sub, least-significant word first.
- Undefined: no req_lock port, no lock state, no chaining.

Decomposition:
- Package adder_arb_pkg: WORD_W=32, stage-1 record typedef (a, b, cin, chain, id), and a helper function for round-robin next-pointer.
- One natural sub-module: rr_arbiter, parameterised NREQ, taking a request vector, pointer and enable, and producing a one-hot grant.
- Instantiate ladner_fischer_adder unchanged.

Test Plan:
- Single op: req 0 with a=0xFFFF_FFFF, b=1, cin=0 -> 2 cycles later rsp_sum=0, rsp_cout=1, rsp_id=0.
- Subtract: req 2 with a=5, b=7, sub=1, cin=1 -> rsp_sum=0xFFFF_FFFE, rsp_cout=0, rsp_id=2.
- Fairness: all 4 requesters continuously valid -> grant order 0,1,2,3,0,…; ids return in the same order at 1 per cycle.
- Backpressure: hold rsp_ready=0 for 5 cycles with traffic pending -> no req_ready, response bit-stable; on release, no loss or duplication, order preserved.
- Reset mid-flight: assert rst_n=0 with both stages full -> rsp_valid=0 immediately, pointer 0; first grant after release goes to the lowest valid index.
- Chained add (ADDER_ARB_LOCK_EN): req 1 sends lo word 0xFFFF_FFFF+1 with lock=1, then hi word 0+0 with lock=0, while req 0 is also valid -> rsp_sum 0 then 1, both with id=1; req 0 is granted only after the hi word.

Source files
------------

// File: rtl/adder_share_arbiter_pkg.sv
// Shared types for the adder-sharing arbiter: word width, stage-1 record, round-robin helper.
package adder_arb_pkg;

  localparam int WORD_W   = 32;
  localparam int ID_MAX_W = 4;   // wide enough for up to 16 requesters

  typedef struct packed {
    logic [WORD_W-1:0]   a;
    logic [WORD_W-1:0]   b;      // already conditionally inverted for subtract
    logic                cin;
    logic                chain;  // take carry-in from the previous result instead of cin
    logic [ID_MAX_W-1:0] id;
  } s1_t;

  function automatic logic [ID_MAX_W-1:0] rr_next(input logic [ID_MAX_W-1:0] idx,
                                                   input int nreq);
    logic [ID_MAX_W:0] nxt;
    nxt = {1'b0, idx} + 1'b1;
    return (int'(nxt) >= nreq) ? '0 : nxt[ID_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle between ALU issue ports and the shared adder.
// ADDER_ARB_LOCK_EN adds the per-requester req_lock vector.
interface adder_share_arbiter_if import adder_arb_pkg::*; #(parameter int NREQ = 4);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*WORD_W-1:0] req_a;
  logic [NREQ*WORD_W-1:0] req_b;
  logic [NREQ-1:0]        req_cin;
  logic [NREQ-1:0]        req_sub;
`ifdef ADDER_ARB_LOCK_EN
  logic [NREQ-1:0]        req_lock;
`endif
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WORD_W-1:0]      rsp_sum;
  logic                   rsp_cout;
  logic [IDW-1:0]         rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_cin, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
`ifdef ADDER_ARB_LOCK_EN
    , output req_lock
`endif
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
`ifdef ADDER_ARB_LOCK_EN
    , input req_lock
`endif
  );

endinterface

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr_i (with wrap) wins.
// Purely combinational; no grant when en_i is low.
module rr_arbiter import adder_arb_pkg::*; #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]     req_i,
  input  logic [ID_MAX_W-1:0] ptr_i,
  input  logic                en_i,
  output logic [NREQ-1:0]     gnt_o,
  output logic [ID_MAX_W-1:0] gnt_idx_o
);

  logic [NREQ-1:0]   rot;
  logic              hit;
  logic [ID_MAX_W:0] off;
  logic [ID_MAX_W:0] pos;

  always_comb begin
    // rot[k] is the request at position (ptr + k) mod NREQ
    rot = NREQ'({req_i, req_i} >> ptr_i);
    hit = |rot;
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = (ID_MAX_W + 1)'(k);
    end
    pos = {1'b0, ptr_i} + off;
    if (pos >= (ID_MAX_W + 1)'(NREQ)) pos = pos - (ID_MAX_W + 1)'(NREQ);
    gnt_idx_o = pos[ID_MAX_W-1:0];
    gnt_o     = '0;
    for (int j = 0; j < NREQ; j++) begin
      gnt_o[j] = en_i & hit & (gnt_idx_o == ID_MAX_W'(j));
    end
  end

endmodule

// File: rtl/ladner_fischer_adder.sv
// Parallel-prefix adder, minimum-depth Ladner-Fischer (Sklansky) carry tree.
module ladner_fischer_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LV = $clog2(WIDTH);

  logic [WIDTH-1:0] gg, pp, gn, pn, p0;
  logic [WIDTH:0]   c;

  always_comb begin
    p0 = a ^ b;
    gg = a & b;
    pp = p0;
    gn = '0;
    pn = '0;
    for (int l = 0; l < LV; l++) begin
      gn = gg;
      pn = pp;
      for (int i = 0; i < WIDTH; i++) begin
        if (((i >> l) & 1) == 1) begin
          gn[i] = gg[i] | (pp[i] & gg[((i >> l) << l) - 1]);
          pn[i] = pp[i] & pp[((i >> l) << l) - 1];
        end
      end
      gg = gn;
      pp = pn;
    end
    // gg/pp now hold group generate/propagate for bits [i:0]
    c    = {gg | (pp & {WIDTH{cin}}), cin};
    sum  = p0 ^ c[WIDTH-1:0];
    cout = c[WIDTH];
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin share of one 32-bit adder: operand register, adder, result register (2-cycle latency).
// ADDER_ARB_LOCK_EN enables lock-and-chain for multi-word arithmetic.
module adder_share_arbiter import adder_arb_pkg::*; #(
  parameter int NREQ = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  adder_share_arbiter_if.slave bus
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic                stall, can_adv, accept;
  logic [NREQ-1:0]     arb_req, gnt;
  logic [ID_MAX_W-1:0] gnt_idx;
  logic [ID_MAX_W-1:0] ptr_q, ptr_d;
  s1_t                 s1_q, s1_d;
  logic                s1_vld_q, s1_vld_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0]   rsp_sum_q, rsp_sum_d;
  logic                rsp_cout_q, rsp_cout_d;
  logic [IDW-1:0]      rsp_id_q, rsp_id_d;
  logic [WORD_W-1:0]   sel_a, sel_b, add_sum;
  logic                sel_cin, sel_sub, add_cin, add_cout;
  logic                unused_id_hi;

`ifdef ADDER_ARB_LOCK_EN
  logic                lock_q, lock_d;
  logic [ID_MAX_W-1:0] lock_id_q, lock_id_d;
  logic                sel_lock;
`else
  logic                unused_chain;
  assign unused_chain = s1_q.chain;
`endif

  assign unused_id_hi = ^(s1_q.id >> IDW);

  assign stall   = rsp_valid_q & ~bus.rsp_ready;
  assign can_adv = ~s1_vld_q | ~stall;

`ifdef ADDER_ARB_LOCK_EN
  assign arb_req = lock_q ? (bus.req_valid & (NREQ'(1) << lock_id_q)) : bus.req_valid;
`else
  assign arb_req = bus.req_valid;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i     (arb_req),
    .ptr_i     (ptr_q),
    .en_i      (can_adv),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign accept = |gnt;

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    sel_sub = 1'b0;
`ifdef ADDER_ARB_LOCK_EN
    sel_lock = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a   = bus.req_a[i*WORD_W +: WORD_W];
        sel_b   = bus.req_b[i*WORD_W +: WORD_W];
        sel_cin = bus.req_cin[i];
        sel_sub = bus.req_sub[i];
`ifdef ADDER_ARB_LOCK_EN
        sel_lock = bus.req_lock[i];
`endif
      end
    end
  end

  // Chained ops take the carry of the preceding word, which sits in the result register.
`ifdef ADDER_ARB_LOCK_EN
  assign add_cin = s1_q.chain ? rsp_cout_q : s1_q.cin;
`else
  assign add_cin = s1_q.cin;
`endif

  ladner_fischer_adder #(.WIDTH(WORD_W)) u_add (
    .a    (s1_q.a),
    .b    (s1_q.b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    s1_d        = s1_q;
    s1_vld_d    = s1_vld_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;
`ifdef ADDER_ARB_LOCK_EN
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
`endif
    if (can_adv) s1_vld_d = accept;
    if (accept) begin
      s1_d.a   = sel_a;
      s1_d.b   = sel_b ^ {WORD_W{sel_sub}};
      s1_d.cin = sel_cin;
      s1_d.id  = gnt_idx;
      ptr_d    = rr_next(gnt_idx, NREQ);
`ifdef ADDER_ARB_LOCK_EN
      s1_d.chain = lock_q;
      lock_d     = sel_lock;
      lock_id_d  = gnt_idx;
`else
      s1_d.chain = 1'b0;
`endif
    end
    if (!stall) begin
      rsp_valid_d = s1_vld_q;
      if (s1_vld_q) begin
        rsp_sum_d  = add_sum;
        rsp_cout_d = add_cout;
        rsp_id_d   = s1_q.id[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s1_vld_q    <= 1'b0;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      s1_q        <= s1_d;
      s1_vld_q    <= s1_vld_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

`ifdef ADDER_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end
`endif

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter; the lock/chain case runs when ADDER_ARB_LOCK_EN is defined.
module tb_adder_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder_share_arbiter_if #(.NREQ(NREQ)) bus ();
  adder_share_arbiter #(.NREQ(NREQ)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  // hand-computed operand/result table for the multi-requester cases
  logic [31:0] fa [4] = '{32'h8000_0001, 32'h1234_5678, 32'hFFFF_0000, 32'h0000_FFFF};
  logic [31:0] fb [4] = '{32'h7FFF_FFFF, 32'h1111_1111, 32'h0001_0000, 32'h0000_0001};
  logic [31:0] es [4] = '{32'h0000_0000, 32'h2345_6789, 32'h0000_0000, 32'h0001_0000};
  logic        ec [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  // backpressure sequence: rsp_ready, req_valid, expected req_ready, rsp_valid, rsp_id
  logic        bp_rr  [12] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  logic [3:0]  bp_vld [12] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
  logic [3:0]  bp_rdy [12] = '{4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0};
  logic        bp_rv  [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int          bp_id  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_rsp(input string tag, input logic vld, input logic [IDW-1:0] id,
                            input logic [31:0] sum, input logic cout);
    check({tag, "_vld"}, 64'(bus.rsp_valid), 64'(vld));
    if (vld) begin
      check({tag, "_id"},   64'(bus.rsp_id),   64'(id));
      check({tag, "_sum"},  64'(bus.rsp_sum),  64'(sum));
      check({tag, "_cout"}, 64'(bus.rsp_cout), 64'(cout));
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
    bus.req_cin[i]        = cin;
    bus.req_sub[i]        = sub;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected finish before 200000");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.req_sub   = '0;
    bus.rsp_ready = 1'b1;
`ifdef ADDER_ARB_LOCK_EN
    bus.req_lock  = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_sum",   64'(bus.rsp_sum),   64'd0);
    check("rst_rsp_cout",  64'(bus.rsp_cout),  64'd0);
    check("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    rst_n = 1'b1;
    tick();

    // single op with full carry-out
    set_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    bus.req_valid = 4'b0001;
    @(negedge clk); check("single_rdy", 64'(bus.req_ready), 64'h1);
    tick(); bus.req_valid = '0;
    @(negedge clk); expect_rsp("single_n1", 1'b0, '0, '0, 1'b0);
    tick();
    @(negedge clk); expect_rsp("single", 1'b1, 2'd0, 32'h0, 1'b1);
    tick();
    @(negedge clk); expect_rsp("single_drain", 1'b0, '0, '0, 1'b0);
    tick();

    // subtract 5 - 7 from requester 2
    set_op(2, 32'd5, 32'd7, 1'b1, 1'b1);
    bus.req_valid = 4'b0100;
    @(negedge clk); check("sub_rdy", 64'(bus.req_ready), 64'h4);
    tick(); bus.req_valid = '0;
    tick();
    @(negedge clk); expect_rsp("sub", 1'b1, 2'd2, 32'hFFFF_FFFE, 1'b0);
    tick();

    // fill both stages (pointer at 3, so grants wrap 3,0,1), then reset mid-flight
    for (int i = 0; i < 4; i++) set_op(i, fa[i], fb[i], 1'b0, 1'b0);
    bus.req_valid = 4'hF;
    @(negedge clk); check("mf_rdy0", 64'(bus.req_ready), 64'h8);
    tick();
    @(negedge clk); check("mf_rdy1", 64'(bus.req_ready), 64'h1);
    tick();
    @(negedge clk); check("mf_rdy2", 64'(bus.req_ready), 64'h2);
    tick();
    check("mf_full_vld", 64'(bus.rsp_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mf_rst_vld",  64'(bus.rsp_valid), 64'd0);
    check("mf_rst_sum",  64'(bus.rsp_sum),   64'd0);
    check("mf_rst_cout", 64'(bus.rsp_cout),  64'd0);
    check("mf_rst_id",   64'(bus.rsp_id),    64'd0);
    bus.req_valid = '0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // fairness: all valid, pointer back at 0 after reset
    for (int c = 0; c < 10; c++) begin
      bus.req_valid = (c < 8) ? 4'hF : 4'h0;
      @(negedge clk);
      check($sformatf("fair_rdy%0d", c), 64'(bus.req_ready),
            64'((c < 8) ? (4'b0001 << (c % 4)) : 4'b0000));
      if (c >= 2)
        expect_rsp($sformatf("fair%0d", c), 1'b1, IDW'((c - 2) % 4), es[(c - 2) % 4], ec[(c - 2) % 4]);
      else
        expect_rsp($sformatf("fair%0d", c), 1'b0, '0, '0, 1'b0);
      tick();
    end

    // backpressure: 5 stalled cycles, response must hold and nothing be granted
    for (int c = 0; c < 12; c++) begin
      bus.rsp_ready = bp_rr[c];
      bus.req_valid = bp_vld[c];
      @(negedge clk);
      check($sformatf("bp_rdy%0d", c), 64'(bus.req_ready), 64'(bp_rdy[c]));
      expect_rsp($sformatf("bp%0d", c), bp_rv[c], IDW'(bp_id[c]), es[bp_id[c]], ec[bp_id[c]]);
      tick();
    end

`ifdef ADDER_ARB_LOCK_EN
    // two-word add from requester 1 under lock while requester 0 keeps asking
    set_op(0, 32'h10, 32'h20, 1'b0, 1'b0);
    bus.req_valid = 4'b0001;
    @(negedge clk); check("lk_rdy0", 64'(bus.req_ready), 64'h1);
    tick();
    set_op(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    bus.req_lock  = 4'b0010;
    bus.req_valid = 4'b0011;
    @(negedge clk); check("lk_rdy1", 64'(bus.req_ready), 64'h2);
    tick();
    set_op(1, 32'h0, 32'h0, 1'b0, 1'b0);
    bus.req_lock  = 4'b0000;
    @(negedge clk); check("lk_rdy2", 64'(bus.req_ready), 64'h2);
    expect_rsp("lk_r0", 1'b1, 2'd0, 32'h30, 1'b0);
    tick();
    bus.req_valid = 4'b0001;
    @(negedge clk); check("lk_rdy3", 64'(bus.req_ready), 64'h1);
    expect_rsp("lk_lo", 1'b1, 2'd1, 32'h0, 1'b1);
    tick();
    bus.req_valid = '0;
    @(negedge clk); expect_rsp("lk_hi", 1'b1, 2'd1, 32'h1, 1'b0);
    tick();
    @(negedge clk); expect_rsp("lk_r0b", 1'b1, 2'd0, 32'h30, 1'b0);
    tick();
    @(negedge clk); expect_rsp("lk_idle", 1'b0, '0, '0, 1'b0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
